// File: rtl/change_dispenser.sv
// Greedy three-tube coin payout with per-coin req/ack handshake and
// no-ack timeout; reports done, sticky fault and unpaid residue.
module change_dispenser #(
   parameter int W       = 8,
   parameter int D2      = 25,
   parameter int D1      = 10,
   parameter int D0      = 1,
   parameter int TIMEOUT = 16
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] amount,
   input  logic [2:0]   empty,
   input  logic         coin_ack,
   output logic         coin_req,
   output logic [2:0]   coin_sel,
   output logic         busy,
   output logic         done,
   output logic         fault,
   output logic [W-1:0] remaining
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] V2 = W'(D2);
   localparam logic [W-1:0] V1 = W'(D1);
   localparam logic [W-1:0] V0 = W'(D0);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, SELECT, REQ, DONE, FAULT
   } state_t;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [W-1:0]  rem_q;
   logic          req_q;
   logic [2:0]    sel_q;
   logic          busy_q;
   logic          done_q;
   logic          fault_q;

   logic [2:0]    pick_d;
   logic [W-1:0]  coin_val;

   // Largest non-empty tube whose coin still fits in the residue.
   always_comb begin
      pick_d = 3'b000;
      if (!empty[2] && rem_q >= V2)      pick_d = 3'b100;
      else if (!empty[1] && rem_q >= V1) pick_d = 3'b010;
      else if (!empty[0] && rem_q >= V0) pick_d = 3'b001;
   end

   always_comb begin
      coin_val = '0;
      unique case (1'b1)
         sel_q[2]: coin_val = V2;
         sel_q[1]: coin_val = V1;
         sel_q[0]: coin_val = V0;
         default:  coin_val = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         rem_q   <= '0;
         req_q   <= 1'b0;
         sel_q   <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, FAULT: begin
               if (start) begin
                  rem_q   <= amount;
                  fault_q <= 1'b0;
                  if (amount == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SELECT;
                     busy_q  <= 1'b1;
                  end
               end
            end
            SELECT: begin
               if (pick_d != 3'b000) begin
                  sel_q   <= pick_d;
                  req_q   <= 1'b1;
                  timer_q <= '0;
                  state_q <= REQ;
               end else if (rem_q == '0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  busy_q  <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end
            end
            REQ: begin
               // A late ack on the timeout cycle still counts as paid.
               if (coin_ack) begin
                  rem_q   <= rem_q - coin_val;
                  req_q   <= 1'b0;
                  sel_q   <= 3'b000;
                  state_q <= SELECT;
               end else if (timer_q == TLAST) begin
                  req_q   <= 1'b0;
                  sel_q   <= 3'b000;
                  busy_q  <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= FAULT;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign coin_req  = req_q;
   assign coin_sel  = sel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fault     = fault_q;
   assign remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, empty tubes,
// fault paths, timeout, ack-at-timeout, busy-start and async reset.
module tb_change_dispenser;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] amount = '0;
   logic [2:0]   empty = 3'b000;
   logic         coin_ack = 1'b0;
   logic         coin_req;
   logic [2:0]   coin_sel;
   logic         busy;
   logic         done;
   logic         fault;
   logic [W-1:0] remaining;

   int checks = 0;
   int errors = 0;

   change_dispenser #(
      .W(W), .D2(25), .D1(10), .D0(1), .TIMEOUT(16)
   ) dut (
      .CLK(CLK),
      .reset(reset),
      .start(start),
      .amount(amount),
      .empty(empty),
      .coin_ack(coin_ack),
      .coin_req(coin_req),
      .coin_sel(coin_sel),
      .busy(busy),
      .done(done),
      .fault(fault),
      .remaining(remaining)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] amt);
      amount = amt;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!coin_req && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, 32'(coin_req), 32'd1);
   endtask

   // Wait for a request, check the tube, ack one cycle later.
   task automatic serve(input string tag, input logic [2:0] exp_sel);
      wait_req(tag);
      chk({tag, "_sel"}, 32'(coin_sel), 32'(exp_sel));
      tick();
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
   endtask

   task automatic finish_done(input string tag);
      tick();
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_rem0"}, 32'(remaining), 32'd0);
      chk({tag, "_busy0"}, 32'(busy), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_req", 32'(coin_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_rem", 32'(remaining), 32'd0);
      tick(2);
      reset = 1'b1;
      tick();

      // T1: 41 = 25 + 10 + 6x1
      empty = 3'b000;
      do_start(8'd41);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_rem", 32'(remaining), 32'd41);
      chk("t1_noreq", 32'(coin_req), 32'd0);
      serve("t1_c25", 3'b100);
      chk("t1_rem16", 32'(remaining), 32'd16);
      serve("t1_c10", 3'b010);
      chk("t1_rem6", 32'(remaining), 32'd6);
      for (int i = 0; i < 6; i++) serve("t1_c1", 3'b001);
      finish_done("t1");

      // T2: zero amount
      do_start(8'd0);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_req", 32'(coin_req), 32'd0);
      tick();
      chk("t2_done_pulse", 32'(done), 32'd0);
      chk("t2_req2", 32'(coin_req), 32'd0);

      // T3: 25 tube empty -> 3 x 10
      empty = 3'b100;
      do_start(8'd30);
      for (int i = 0; i < 3; i++) serve("t3_c10", 3'b010);
      finish_done("t3");

      // T4: cannot make change
      empty = 3'b001;
      do_start(8'd7);
      chk("t4_fault_early", 32'(fault), 32'd0);
      tick();
      chk("t4_fault", 32'(fault), 32'd1);
      chk("t4_rem", 32'(remaining), 32'd7);
      chk("t4_req", 32'(coin_req), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      tick(3);
      chk("t4_sticky", 32'(fault), 32'd1);
      empty = 3'b000;
      do_start(8'd5);
      chk("t4_fault_clr", 32'(fault), 32'd0);
      chk("t4_rem5", 32'(remaining), 32'd5);
      for (int i = 0; i < 5; i++) serve("t4_c1", 3'b001);
      finish_done("t4");

      // T5: ack withheld -> timeout after 16 request cycles
      do_start(8'd12);
      wait_req("t5");
      chk("t5_sel", 32'(coin_sel), 32'b010);
      begin
         int hi = 0;
         while (coin_req && hi < 40) begin
            hi++;
            tick();
         end
         chk("t5_hi_cycles", 32'(hi), 32'd16);
      end
      chk("t5_fault", 32'(fault), 32'd1);
      chk("t5_rem", 32'(remaining), 32'd12);
      chk("t5_sel0", 32'(coin_sel), 32'd0);

      // T6a: start from FAULT, ignored start while busy, ack on last cycle
      do_start(8'd12);
      chk("t6a_fault_clr", 32'(fault), 32'd0);
      wait_req("t6a");
      tick(5);
      amount = 8'd99;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      chk("t6a_busy_start", 32'(remaining), 32'd12);
      tick(9);
      chk("t6a_still_req", 32'(coin_req), 32'd1);
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      chk("t6a_ack_wins", 32'(fault), 32'd0);
      chk("t6a_rem2", 32'(remaining), 32'd2);
      chk("t6a_busy", 32'(busy), 32'd1);
      serve("t6a_c1", 3'b001);
      serve("t6a_c1", 3'b001);
      finish_done("t6a");

      // T6b: async reset during the second coin of T1
      do_start(8'd41);
      serve("t6b_c25", 3'b100);
      wait_req("t6b");
      chk("t6b_sel", 32'(coin_sel), 32'b010);
      reset = 1'b0;
      #1;
      chk("t6b_req", 32'(coin_req), 32'd0);
      chk("t6b_busy", 32'(busy), 32'd0);
      chk("t6b_rem", 32'(remaining), 32'd0);
      chk("t6b_sel0", 32'(coin_sel), 32'd0);
      #2;
      reset = 1'b1;
      tick(3);
      chk("t6b_idle_req", 32'(coin_req), 32'd0);
      chk("t6b_idle_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
